// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 system-control coprocessor: register indices,
// exception codes and SR/Cause field positions.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  // Interrupt-line index inside the 6-bit IP/IM field driven by the timer.
  localparam int IP_TIMER = 5;

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_count_timer.sv
// Count/Compare timer: prescaled 32-bit Count, Compare register and the
// sticky timer-interrupt flag TI.
module cp0_count_timer #(
  parameter int COUNT_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_count,
  input  logic        we_compare,
  input  logic [31:0] wd,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam logic [7:0] PRESC_LAST = 8'(COUNT_DIV - 1);

  logic [7:0]  r_presc;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic        w_tick;
  logic        w_match;

  assign w_tick  = (r_presc == PRESC_LAST);
  assign w_match = (r_count == r_compare);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc   <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      if (we_count) begin
        r_count <= wd;
        r_presc <= '0;
      end else if (w_tick) begin
        r_count <= r_count + 32'd1;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 8'd1;
      end
      if (we_compare) r_compare <= wd;
      // A Compare write acknowledges the timer even if a match lands the same cycle.
      if (we_compare)   r_ti <= 1'b0;
      else if (w_match) r_ti <= 1'b1;
    end
  end

  assign count   = r_count;
  assign compare = r_compare;
  assign ti      = r_ti;

endmodule

// File: rtl/cp0_timer_ctrl.sv
// CP0 beside the M stage: SR/Cause/EPC/BadVAddr/PRId plus optional Count/Compare
// timer, with a combinational exception/interrupt request to the pipeline.
module cp0_timer_ctrl
  import cp0_pkg::*;
#(
  parameter int          N_EXT     = 5,
  parameter bit          TIMER_EN  = 1'b1,
  parameter int          COUNT_DIV = 1,
  parameter logic [31:0] PRID      = 32'h0125_0817
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_EXT-1:0] hw_int,
  input  logic [31:0]      pc,
  input  logic             bd,
  input  logic [4:0]       excode,
  input  logic [31:0]      bad_vaddr_in,
  input  logic             eret,
  input  logic             we,
  input  logic [4:0]       rd_addr,
  input  logic [31:0]      wd,
  output logic             req,
  output logic [31:0]      epc_out,
  output logic [31:0]      rdata
);

  logic        r_ie;
  logic        r_exl;
  logic [5:0]  r_im;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;

  logic [5:0]  w_ip_next;
  logic        w_exc;
  logic        w_irq;
  logic        w_req;
  logic        w_we_ok;
  logic        w_ti;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic [31:0] w_epc_out;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_ip
      if (gi < N_EXT) begin : g_ext
        assign w_ip_next[gi] = hw_int[gi];
      end else if (gi == IP_TIMER && TIMER_EN) begin : g_tmr
        assign w_ip_next[gi] = w_ti;
      end else begin : g_zero
        assign w_ip_next[gi] = 1'b0;
      end
    end
  endgenerate

  assign w_exc   = (excode != EXC_INT);
  assign w_irq   = (|(r_ip & r_im)) & r_ie & ~r_exl;
  assign w_req   = w_exc | w_irq;
  // mtc0 in the same cycle as a taken exception/interrupt is squashed.
  assign w_we_ok = we & ~w_req;

  generate
    if (TIMER_EN) begin : g_timer
      cp0_count_timer #(
        .COUNT_DIV (COUNT_DIV)
      ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .we_count   (w_we_ok && rd_addr == REG_COUNT),
        .we_compare (w_we_ok && rd_addr == REG_COMPARE),
        .wd         (wd),
        .count      (w_count),
        .compare    (w_compare),
        .ti         (w_ti)
      );
    end else begin : g_no_timer
      assign w_count   = '0;
      assign w_compare = '0;
      assign w_ti      = 1'b0;
    end
  endgenerate

  assign w_epc_out = w_req ? (bd ? pc - 32'd4 : pc) : r_epc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ie       <= 1'b0;
      r_exl      <= 1'b0;
      r_im       <= '0;
      r_bd       <= 1'b0;
      r_ip       <= '0;
      r_exccode  <= EXC_INT;
      r_epc      <= '0;
      r_badvaddr <= '0;
    end else begin
      r_ip <= w_ip_next;
      if (w_req) begin
        // Taking the trap overrides any eret or mtc0 in the same cycle.
        r_exl     <= 1'b1;
        r_exccode <= w_exc ? excode : EXC_INT;
        r_bd      <= bd;
        r_epc     <= w_epc_out;
        if (is_addr_exc(excode)) r_badvaddr <= bad_vaddr_in;
      end else begin
        if (w_we_ok && rd_addr == REG_SR) begin
          r_ie  <= wd[SR_IE];
          r_exl <= wd[SR_EXL];
          r_im  <= wd[SR_IM_HI:SR_IM_LO];
        end
        if (w_we_ok && rd_addr == REG_EPC) r_epc <= wd;
        if (eret) r_exl <= 1'b0;
      end
    end
  end

  assign w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'b0, r_ip, 3'b0, r_exccode, 2'b0};

  always_comb begin
    rdata = '0;
    case (rd_addr)
      REG_BADVADDR: rdata = r_badvaddr;
      REG_COUNT:    rdata = w_count;
      REG_COMPARE:  rdata = w_compare;
      REG_SR:       rdata = w_sr;
      REG_CAUSE:    rdata = w_cause;
      REG_EPC:      rdata = w_epc_out;
      REG_PRID:     rdata = PRID;
      default:      rdata = '0;
    endcase
  end

  assign req     = w_req;
  assign epc_out = w_epc_out;

endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// Directed self-checking bench for cp0_timer_ctrl: one prescaled instance and
// one COUNT_DIV=1 instance for the Count wrap scenario.
module tb_cp0_timer_ctrl;

  localparam logic [31:0] PRID_V = 32'h0125_0817;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  hw_int = '0;
  logic [31:0] pc = '0;
  logic        bd = 1'b0;
  logic [4:0]  excode = '0;
  logic [31:0] bad_vaddr_in = '0;
  logic        eret = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] wd = '0;
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] rdata;

  logic [4:0]  hw_int1 = '0;
  logic [31:0] zero32 = '0;
  logic        zero1 = 1'b0;
  logic [4:0]  zero5 = '0;
  logic        we1 = 1'b0;
  logic [4:0]  rd_addr1 = '0;
  logic [31:0] wd1 = '0;
  logic        req1;
  logic [31:0] epc_out1;
  logic [31:0] rdata1;

  int checks = 0;
  int errors = 0;
  logic [31:0] v;

  always #5 clk = ~clk;

  cp0_timer_ctrl #(.N_EXT(5), .TIMER_EN(1'b1), .COUNT_DIV(4), .PRID(PRID_V)) dut (
    .clk(clk), .reset(reset), .hw_int(hw_int), .pc(pc), .bd(bd), .excode(excode),
    .bad_vaddr_in(bad_vaddr_in), .eret(eret), .we(we), .rd_addr(rd_addr), .wd(wd),
    .req(req), .epc_out(epc_out), .rdata(rdata)
  );

  cp0_timer_ctrl #(.N_EXT(5), .TIMER_EN(1'b1), .COUNT_DIV(1), .PRID(PRID_V)) dut1 (
    .clk(clk), .reset(reset), .hw_int(hw_int1), .pc(zero32), .bd(zero1), .excode(zero5),
    .bad_vaddr_in(zero32), .eret(zero1), .we(we1), .rd_addr(rd_addr1), .wd(wd1),
    .req(req1), .epc_out(epc_out1), .rdata(rdata1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; rd_addr = a; wd = d;
    step();
    we = 1'b0;
  endtask

  task automatic mtc0_1(input logic [4:0] a, input logic [31:0] d);
    we1 = 1'b1; rd_addr1 = a; wd1 = d;
    step();
    we1 = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] val);
    rd_addr = a;
    #1;
    val = rdata;
  endtask

  task automatic rd1(input logic [4:0] a, output logic [31:0] val);
    rd_addr1 = a;
    #1;
    val = rdata1;
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", req); end
    checks++; if (epc_out !== 32'h0) begin errors++; $display("FAIL rst_epc_out: got %h expected 0", epc_out); end
    rd(5'd15, v);
    checks++; if (v !== PRID_V) begin errors++; $display("FAIL rst_prid: got %h expected %h", v, PRID_V); end
    rd(5'd12, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_sr: got %h expected 0", v); end
    rd(5'd13, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_cause: got %h expected 0", v); end
    rd(5'd9, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_count: got %h expected 0", v); end
    reset = 1'b0;
    // Park Compare far away so the post-reset Count==Compare match never sets TI.
    mtc0(5'd11, 32'hFFFF_0000);
    $display("test_reset done");
  endtask

  task automatic test_interrupt();
    pc = 32'h0000_2000; bd = 1'b0;
    mtc0(5'd12, 32'h0000_FC01);
    hw_int = 5'b00100;
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL int_pre_sample: got %b expected 0", req); end
    step();
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL int_req: got %b expected 1", req); end
    checks++; if (epc_out !== 32'h2000) begin errors++; $display("FAIL int_epc_bypass: got %h expected 2000", epc_out); end
    rd(5'd13, v);
    checks++; if (v !== 32'h0000_1000) begin errors++; $display("FAIL int_cause_ip12: got %h expected 00001000", v); end
    rd(5'd14, v);
    checks++; if (v !== 32'h2000) begin errors++; $display("FAIL int_rd_epc_bypass: got %h expected 2000", v); end
    step();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL int_masked_exl: got %b expected 0", req); end
    rd(5'd12, v);
    checks++; if (v !== 32'h0000_FC03) begin errors++; $display("FAIL int_sr_exl: got %h expected 0000fc03", v); end
    rd(5'd14, v);
    checks++; if (v !== 32'h2000) begin errors++; $display("FAIL int_epc: got %h expected 2000", v); end
    hw_int = 5'b00101;
    step();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL int_second_masked: got %b expected 0", req); end
    eret = 1'b1;
    step();
    eret = 1'b0;
    #1;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL int_after_eret: got %b expected 1", req); end
    hw_int = 5'b00000;
    step();
    $display("test_interrupt done");
  endtask

  task automatic test_exception();
    excode = 5'd4; bd = 1'b1; pc = 32'h0000_3008; bad_vaddr_in = 32'h0000_1001;
    #1;
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL exc_req: got %b expected 1", req); end
    checks++; if (epc_out !== 32'h3004) begin errors++; $display("FAIL exc_epc_out_bd: got %h expected 3004", epc_out); end
    step();
    excode = 5'd0; bd = 1'b0;
    rd(5'd13, v);
    checks++; if (v !== 32'h8000_0010) begin errors++; $display("FAIL exc_cause: got %h expected 80000010", v); end
    rd(5'd14, v);
    checks++; if (v !== 32'h3004) begin errors++; $display("FAIL exc_epc: got %h expected 3004", v); end
    rd(5'd8, v);
    checks++; if (v !== 32'h1001) begin errors++; $display("FAIL exc_badvaddr: got %h expected 1001", v); end
    $display("test_exception done");
  endtask

  task automatic test_simultaneous();
    eret = 1'b1; excode = 5'd12; pc = 32'h0000_4000; bd = 1'b0; bad_vaddr_in = 32'hDEAD_BEEF;
    step();
    eret = 1'b0; excode = 5'd0;
    rd(5'd12, v);
    checks++; if (v !== 32'h0000_FC03) begin errors++; $display("FAIL sim_eret_req_sr: got %h expected 0000fc03", v); end
    rd(5'd13, v);
    checks++; if (v !== 32'h0000_0030) begin errors++; $display("FAIL sim_eret_req_cause: got %h expected 00000030", v); end
    rd(5'd8, v);
    checks++; if (v !== 32'h1001) begin errors++; $display("FAIL sim_badvaddr_kept: got %h expected 1001", v); end
    we = 1'b1; rd_addr = 5'd12; wd = 32'h0; excode = 5'd10; pc = 32'h0000_5000;
    step();
    we = 1'b0; excode = 5'd0;
    rd(5'd12, v);
    checks++; if (v !== 32'h0000_FC03) begin errors++; $display("FAIL sim_we_req_sr: got %h expected 0000fc03", v); end
    rd(5'd13, v);
    checks++; if (v !== 32'h0000_0028) begin errors++; $display("FAIL sim_we_req_cause: got %h expected 00000028", v); end
    we = 1'b1; rd_addr = 5'd12; wd = 32'h0000_0403; eret = 1'b1;
    step();
    we = 1'b0; eret = 1'b0;
    rd(5'd12, v);
    checks++; if (v !== 32'h0000_0401) begin errors++; $display("FAIL sim_we_eret_sr: got %h expected 00000401", v); end
    $display("test_simultaneous done");
  endtask

  task automatic test_timer();
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'h3);
    repeat (11) step();
    rd(5'd9, v);
    checks++; if (v !== 32'h3) begin errors++; $display("FAIL tmr_count3: got %h expected 3", v); end
    step();
    rd(5'd13, v);
    checks++; if (v !== 32'h0000_0028) begin errors++; $display("FAIL tmr_ip_not_yet: got %h expected 00000028", v); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL tmr_req_not_yet: got %b expected 0", req); end
    step();
    rd(5'd13, v);
    checks++; if (v !== 32'h0000_8028) begin errors++; $display("FAIL tmr_ip15: got %h expected 00008028", v); end
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL tmr_req: got %b expected 1", req); end
    step();
    mtc0(5'd11, 32'h100);
    step();
    rd(5'd13, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL tmr_ti_cleared: got %h expected 0", v); end
    eret = 1'b1;
    step();
    eret = 1'b0;
    rd(5'd12, v);
    checks++; if (v !== 32'h0000_8001) begin errors++; $display("FAIL tmr_sr_after_eret: got %h expected 00008001", v); end
    $display("test_timer done");
  endtask

  task automatic test_wrap();
    mtc0_1(5'd11, 32'h0);
    mtc0_1(5'd9, 32'hFFFF_FFFF);
    rd1(5'd9, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_load: got %h expected ffffffff", v); end
    step();
    rd1(5'd9, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h expected 0", v); end
    rd1(5'd13, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL wrap_no_ip_yet: got %h expected 0", v); end
    step(); step();
    rd1(5'd13, v);
    checks++; if (v !== 32'h0000_8000) begin errors++; $display("FAIL wrap_match_ip15: got %h expected 00008000", v); end
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid();
    mtc0(5'd12, 32'h0);
    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'h1);
    repeat (8) step();
    rd(5'd13, v);
    checks++; if (v !== 32'h0000_8000) begin errors++; $display("FAIL mid_ti_set: got %h expected 00008000", v); end
    hw_int = 5'b11111;
    #3;
    reset = 1'b1;
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL mid_req: got %b expected 0", req); end
    checks++; if (epc_out !== 32'h0) begin errors++; $display("FAIL mid_epc_out: got %h expected 0", epc_out); end
    rd(5'd13, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_cause: got %h expected 0", v); end
    rd(5'd11, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_compare: got %h expected 0", v); end
    rd(5'd8, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_badvaddr: got %h expected 0", v); end
    step(); step();
    rd(5'd13, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_cause_held: got %h expected 0", v); end
    rd(5'd9, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_count_held: got %h expected 0", v); end
    rd(5'd15, v);
    checks++; if (v !== PRID_V) begin errors++; $display("FAIL mid_prid: got %h expected %h", v, PRID_V); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL mid_req_held: got %b expected 0", req); end
    reset = 1'b0;
    hw_int = '0;
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_exception();
    test_simultaneous();
    test_timer();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
